// File: rtl/mult_div_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
// Holds op encodings, FSM state encoding and the iteration count.
// No logic; imported by the interface user and the top.
package mult_div_pkg;

    localparam logic OP_MULT  = 1'b0;
    localparam logic OP_DIV   = 1'b1;

    localparam int   MD_STEPS = 32;
    localparam int   CNT_W    = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MULT = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } md_state_t;

endpackage

// File: rtl/mult_div_if.sv
// Request/response bundle between the controller and the mult/div unit.
// Latency is set by the unit; the bundle itself is plain wires.
// No flow control beyond start/busy/done; start is dropped while busy.
interface mult_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Controller side: issues requests, observes status and results.
    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, hi, lo
    );

    // Unit side: consumes requests, produces status and results.
    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div.sv
// Iterative signed multiply (radix-2 Booth) / restoring divide producing hi/lo.
// Latency: mult done at k+33, div done at k+34, div-by-zero done at k+1.
// No backpressure: start is ignored unless IDLE; results hold until next completion.
module mult_div
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    mult_div_if.slave md
);

    localparam int AW = 2 * WIDTH + 1;

    md_state_t        state;
    md_state_t        state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [AW-1:0]    acc;
    logic [WIDTH-1:0] opnd;
    logic             a_neg;
    logic             b_neg;
    logic             dz_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             accept;
    logic             b_zero;
    logic             last_step;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH:0]   upper_ext;
    logic [WIDTH:0]   booth_sum;
    logic [AW-1:0]    mult_step;

    logic [AW-1:0]    div_shift;
    logic [WIDTH+1:0] div_trial;
    logic [AW-1:0]    div_step;

    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    logic             busy_o;
    logic             done_o;
    logic             dz_o;

    // Request decode and operand magnitudes used by the divider.
    always_comb begin
        accept    = (state == ST_IDLE) && md.start;
        b_zero    = (md.b == '0);
        last_step = (cnt == CNT_W'(MD_STEPS - 1));
        a_mag     = md.a[WIDTH-1] ? (~md.a + 1'b1) : md.a;
        b_mag     = md.b[WIDTH-1] ? (~md.b + 1'b1) : md.b;
    end

    // One Booth step: acc = {upper, multiplier/lower, q-1}. The add is done
    // one bit wider so that subtracting the most negative multiplicand cannot
    // overflow before the arithmetic shift.
    always_comb begin
        upper_ext = {acc[AW-1], acc[AW-1:WIDTH+1]};
        case (acc[1:0])
            2'b01:   booth_sum = upper_ext + {opnd[WIDTH-1], opnd};
            2'b10:   booth_sum = upper_ext - {opnd[WIDTH-1], opnd};
            default: booth_sum = upper_ext;
        endcase
        mult_step = {booth_sum, acc[WIDTH:1]};
    end

    // One restoring-division step on magnitudes: acc = {rem(W+1), quot(W)}.
    always_comb begin
        div_shift = {acc[AW-2:0], 1'b0};
        div_trial = {1'b0, div_shift[AW-1:WIDTH]} - {2'b00, opnd};
        if (!div_trial[WIDTH+1]) begin
            div_step = {div_trial[WIDTH:0], div_shift[WIDTH-1:1], 1'b1};
        end else begin
            div_step = div_shift;
        end
    end

    // Sign correction: quotient negated on sign mismatch, remainder follows dividend.
    always_comb begin
        q_mag = acc[WIDTH-1:0];
        r_mag = acc[2*WIDTH-1:WIDTH];
        q_fix = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
        r_fix = a_neg ? (~r_mag + 1'b1) : r_mag;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (md.start) begin
                    if (md.op == OP_MULT) begin
                        state_nxt = ST_MULT;
                    end else if (b_zero) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_DIV;
                    end
                end
            end
            ST_MULT: if (last_step) state_nxt = ST_DONE;
            ST_DIV:  if (last_step) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs, decoded from registered state only.
    always_comb begin
        busy_o = (state == ST_MULT) || (state == ST_DIV) || (state == ST_FIX);
        done_o = (state == ST_DONE);
        dz_o   = (state == ST_DONE) && dz_q;
    end

    // Datapath: operand capture, iteration, and result write on completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            acc   <= '0;
            opnd  <= '0;
            a_neg <= 1'b0;
            b_neg <= 1'b0;
            dz_q  <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            dz_q <= accept && (md.op == OP_DIV) && b_zero;
            case (state)
                ST_IDLE: begin
                    if (md.start) begin
                        cnt   <= '0;
                        a_neg <= md.a[WIDTH-1];
                        b_neg <= md.b[WIDTH-1];
                        if (md.op == OP_MULT) begin
                            opnd <= md.a;
                            acc  <= {{WIDTH{1'b0}}, md.b, 1'b0};
                        end else begin
                            opnd <= b_mag;
                            acc  <= {{(WIDTH+1){1'b0}}, a_mag};
                        end
                    end
                end
                ST_MULT: begin
                    acc <= mult_step;
                    cnt <= cnt + CNT_W'(1);
                    if (last_step) begin
                        hi_q <= mult_step[AW-1:WIDTH+1];
                        lo_q <= mult_step[WIDTH:1];
                    end
                end
                ST_DIV: begin
                    acc <= div_step;
                    cnt <= cnt + CNT_W'(1);
                end
                ST_FIX: begin
                    hi_q <= r_fix;
                    lo_q <= q_fix;
                end
                default: ;
            endcase
        end
    end

    assign md.busy     = busy_o;
    assign md.done     = done_o;
    assign md.div_zero = dz_o;
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;

endmodule

// File: tb/tb_mult_div.sv
// Directed bench for mult_div: reset, Booth mult, signed div, div-by-zero,
// start-while-busy, mid-operation reset abort, overflow wrap, back-to-back.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_mult_div;

    logic clk;
    logic reset;

    int n_checks = 0;
    int n_fail   = 0;

    mult_div_if #(.WIDTH(32)) md ();

    mult_div #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pulse start for one cycle; returns at the falling edge of cycle k+1.
    task automatic issue(input logic o, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        md.start = 1'b1;
        md.op    = o;
        md.a     = av;
        md.b     = bv;
        @(negedge clk);
        md.start = 1'b0;
    endtask

    // Returns latency (cycle index after k where done is seen) and busy cycles.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 1;
        bcnt = 0;
        while (md.done !== 1'b1 && lat < 100) begin
            if (md.busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        md.start = 1'b0;
        md.op    = 1'b0;
        md.a     = '0;
        md.b     = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (md.busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", md.busy); end
        n_checks++; if (md.done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b expected 0", md.done); end
        n_checks++; if (md.div_zero !== 1'b0) begin n_fail++; $display("FAIL reset div_zero: got %b expected 0", md.div_zero); end
        n_checks++; if (md.hi !== 32'h0) begin n_fail++; $display("FAIL reset hi: got %h expected 0", md.hi); end
        n_checks++; if (md.lo !== 32'h0) begin n_fail++; $display("FAIL reset lo: got %h expected 0", md.lo); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int lat, bc;
        issue(1'b0, 32'd7, 32'hFFFF_FFFD);
        wait_done(lat, bc);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL mult latency: got %0d expected 33", lat); end
        n_checks++; if (bc !== 32) begin n_fail++; $display("FAIL mult busy cycles: got %0d expected 32", bc); end
        n_checks++; if (md.busy !== 1'b0) begin n_fail++; $display("FAIL mult busy at done: got %b expected 0", md.busy); end
        n_checks++; if (md.div_zero !== 1'b0) begin n_fail++; $display("FAIL mult div_zero: got %b expected 0", md.div_zero); end
        n_checks++; if (md.hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult 7x-3 hi: got %h expected ffffffff", md.hi); end
        n_checks++; if (md.lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult 7x-3 lo: got %h expected ffffffeb", md.lo); end
        @(negedge clk);
        n_checks++; if (md.done !== 1'b0) begin n_fail++; $display("FAIL mult done pulse width: got %b expected 0", md.done); end
        n_checks++; if (md.lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult lo hold: got %h expected ffffffeb", md.lo); end

        issue(1'b0, 32'h8000_0000, 32'h8000_0000);
        wait_done(lat, bc);
        n_checks++; if (md.hi !== 32'h4000_0000) begin n_fail++; $display("FAIL mult minneg hi: got %h expected 40000000", md.hi); end
        n_checks++; if (md.lo !== 32'h0000_0000) begin n_fail++; $display("FAIL mult minneg lo: got %h expected 0", md.lo); end
    endtask

    task automatic test_div_signs();
        int lat, bc;
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, bc);
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL div latency: got %0d expected 34", lat); end
        n_checks++; if (bc !== 33) begin n_fail++; $display("FAIL div busy cycles: got %0d expected 33", bc); end
        n_checks++; if (md.lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div -7/2 lo: got %h expected fffffffd", md.lo); end
        n_checks++; if (md.hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div -7/2 hi: got %h expected ffffffff", md.hi); end
        n_checks++; if (md.div_zero !== 1'b0) begin n_fail++; $display("FAIL div -7/2 div_zero: got %b expected 0", md.div_zero); end

        issue(1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_done(lat, bc);
        n_checks++; if (md.lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div 7/-2 lo: got %h expected fffffffd", md.lo); end
        n_checks++; if (md.hi !== 32'h0000_0001) begin n_fail++; $display("FAIL div 7/-2 hi: got %h expected 1", md.hi); end
    endtask

    task automatic test_div_zero();
        int lat, bc;
        // 620 * 124692599 = 0x12_0000_0034
        issue(1'b0, 32'd620, 32'd124692599);
        wait_done(lat, bc);
        n_checks++; if (md.hi !== 32'h12) begin n_fail++; $display("FAIL dz setup hi: got %h expected 12", md.hi); end
        n_checks++; if (md.lo !== 32'h34) begin n_fail++; $display("FAIL dz setup lo: got %h expected 34", md.lo); end

        issue(1'b1, 32'd5, 32'd0);
        n_checks++; if (md.done !== 1'b1) begin n_fail++; $display("FAIL dz done at k+1: got %b expected 1", md.done); end
        n_checks++; if (md.div_zero !== 1'b1) begin n_fail++; $display("FAIL dz flag at k+1: got %b expected 1", md.div_zero); end
        n_checks++; if (md.busy !== 1'b0) begin n_fail++; $display("FAIL dz busy: got %b expected 0", md.busy); end
        n_checks++; if (md.hi !== 32'h12) begin n_fail++; $display("FAIL dz hi held: got %h expected 12", md.hi); end
        n_checks++; if (md.lo !== 32'h34) begin n_fail++; $display("FAIL dz lo held: got %h expected 34", md.lo); end
        @(negedge clk);
        n_checks++; if (md.done !== 1'b0) begin n_fail++; $display("FAIL dz done width: got %b expected 0", md.done); end
        n_checks++; if (md.div_zero !== 1'b0) begin n_fail++; $display("FAIL dz flag width: got %b expected 0", md.div_zero); end
    endtask

    task automatic test_abort();
        int lat, bc, seen_done, seen_busy;
        issue(1'b0, 32'h1234, 32'h5678);          // now in cycle k+1
        repeat (3) @(negedge clk);                 // cycle k+4
        md.start = 1'b1;
        md.op    = 1'b1;
        md.a     = 32'd100;
        md.b     = 32'd0;
        @(negedge clk);                            // cycle k+5
        md.start = 1'b0;
        n_checks++; if (md.busy !== 1'b1) begin n_fail++; $display("FAIL abort busy after ignored start: got %b expected 1", md.busy); end
        n_checks++; if (md.div_zero !== 1'b0) begin n_fail++; $display("FAIL abort ignored start div_zero: got %b expected 0", md.div_zero); end
        repeat (5) @(negedge clk);                 // cycle k+10
        reset = 1'b0;
        #1;
        n_checks++; if (md.busy !== 1'b0) begin n_fail++; $display("FAIL abort reset busy: got %b expected 0", md.busy); end
        n_checks++; if (md.done !== 1'b0) begin n_fail++; $display("FAIL abort reset done: got %b expected 0", md.done); end
        n_checks++; if (md.hi !== 32'h0) begin n_fail++; $display("FAIL abort reset hi: got %h expected 0", md.hi); end
        n_checks++; if (md.lo !== 32'h0) begin n_fail++; $display("FAIL abort reset lo: got %h expected 0", md.lo); end
        @(negedge clk);
        reset = 1'b1;
        seen_done = 0;
        seen_busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (md.done === 1'b1) seen_done++;
            if (md.busy === 1'b1) seen_busy++;
        end
        n_checks++; if (seen_done !== 0) begin n_fail++; $display("FAIL abort stray done: got %0d expected 0", seen_done); end
        n_checks++; if (seen_busy !== 0) begin n_fail++; $display("FAIL abort stray busy: got %0d expected 0", seen_busy); end

        issue(1'b0, 32'd3, 32'd4);
        wait_done(lat, bc);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL post-reset mult latency: got %0d expected 33", lat); end
        n_checks++; if (md.lo !== 32'd12) begin n_fail++; $display("FAIL post-reset 3x4 lo: got %h expected c", md.lo); end
        n_checks++; if (md.hi !== 32'd0) begin n_fail++; $display("FAIL post-reset 3x4 hi: got %h expected 0", md.hi); end
    endtask

    task automatic test_div_overflow();
        int lat, bc;
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bc);
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL ovf latency: got %0d expected 34", lat); end
        n_checks++; if (md.lo !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf lo: got %h expected 80000000", md.lo); end
        n_checks++; if (md.hi !== 32'h0) begin n_fail++; $display("FAIL ovf hi: got %h expected 0", md.hi); end
        n_checks++; if (md.div_zero !== 1'b0) begin n_fail++; $display("FAIL ovf div_zero: got %b expected 0", md.div_zero); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        issue(1'b0, 32'd6, 32'hFFFF_FFF9);         // 6 * -7 = -42
        wait_done(lat, bc);
        n_checks++; if (md.lo !== 32'hFFFF_FFD6) begin n_fail++; $display("FAIL b2b mult lo: got %h expected ffffffd6", md.lo); end
        n_checks++; if (md.hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL b2b mult hi: got %h expected ffffffff", md.hi); end
        issue(1'b1, 32'd100, 32'd7);               // start in the cycle right after done
        wait_done(lat, bc);
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL b2b div latency: got %0d expected 34", lat); end
        n_checks++; if (md.lo !== 32'd14) begin n_fail++; $display("FAIL b2b div lo: got %h expected e", md.lo); end
        n_checks++; if (md.hi !== 32'd2) begin n_fail++; $display("FAIL b2b div hi: got %h expected 2", md.hi); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div_signs();
        test_div_zero();
        test_abort();
        test_div_overflow();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
